// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide issue controller.
// Used by md_issue_ctrl and the optional md_watchdog (MD_WATCHDOG_EN).
package md_issue_ctrl_pkg;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int WD_SLACK = 4;
  localparam int WD_CNT_W = 5;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHL  = 3'd5,
    MD_MTHL  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_e;

  typedef enum logic {
    KIND_MUL = 1'b0,
    KIND_DIV = 1'b1
  } md_kind_e;

  function automatic logic is_mul_class(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic md_kind_e kind_of(input logic [2:0] op);
    return ((op == MD_DIV) || (op == MD_DIVU)) ? KIND_DIV : KIND_MUL;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_watchdog.sv
// Watchdog for the multiply/divide unit: counts cycles an operation is in flight
// and raises a sticky timeout once the count passes the expected latency plus slack.
module md_watchdog
  import md_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       launch_i,
  input  logic [2:0] op_i,
  input  logic       active_i,
  output logic       timeout_o
);

  md_kind_e            kind_q, kind_d;
  logic [WD_CNT_W-1:0] count_q, count_d;
  logic [WD_CNT_W-1:0] limit;
  logic                timeout_q, timeout_d;

  // The counter saturates so a hung unit cannot wrap it back under the limit.
  always_comb begin
    kind_d    = kind_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    limit     = (kind_q == KIND_MUL) ? WD_CNT_W'(MULT_LAT + WD_SLACK)
                                     : WD_CNT_W'(DIV_LAT + WD_SLACK);
    if (launch_i) begin
      kind_d  = kind_of(op_i);
      count_d = '0;
    end else if (active_i) begin
      if (count_q > limit) timeout_d = 1'b1;
      if (count_q != '1)   count_d   = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q    <= KIND_MUL;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      kind_q    <= kind_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue and interlock controller for the HI/LO multiply/divide unit.
// Define MD_WATCHDOG_EN to build md_watchdog and drive md_timeout; otherwise md_timeout is 0.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] d_md_op,
  input  logic [2:0] e_md_op,
  input  logic       e_valid,
  input  logic       exc_flush,
  input  logic       md_busy,
  output logic       md_start,
  output logic       stall_d,
  output logic       md_pending,
  output logic       md_done,
  output logic       md_proto_err,
  output logic       md_timeout
);

  md_state_e state_q;
  logic      proto_err_q;
  logic      e_mul;
  logic      d_any;

  assign e_mul = is_mul_class(e_md_op);
  assign d_any = (d_md_op != MD_NONE);

  // Busy is invisible during the start cycle and must be trusted from LAUNCH on;
  // in WAIT the stall drops the first cycle busy reads low so HI/LO readers advance.
  assign md_start   = e_valid && e_mul && !exc_flush && (state_q == ST_IDLE);
  assign stall_d    = d_any && (md_start || (state_q == ST_LAUNCH) ||
                                ((state_q == ST_WAIT) && md_busy));
  assign md_pending = (state_q != ST_IDLE);
  assign md_done    = (state_q == ST_WAIT) && !md_busy;
  assign md_proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      if (e_valid && e_mul && (state_q != ST_IDLE)) proto_err_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (md_start) state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
          if (!md_busy) proto_err_q <= 1'b1;
        end
        ST_WAIT: begin
          if (!md_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MD_WATCHDOG_EN
  md_watchdog u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .launch_i  (md_start),
    .op_i      (e_md_op),
    .active_i  (md_pending),
    .timeout_o (md_timeout)
  );
`else
  assign md_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed vector table, corner sequences,
// and randomized traffic against a cycle-count reference model with a busy-unit model.
module tb_md_issue_ctrl;

  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MFHL = 3'd5, MTHL = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dOp, eOp;
  logic       eValid, excFlush, mdBusy;
  logic       mdStart, stallD, mdPending, mdDone, mdProtoErr, mdTimeout;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .d_md_op      (dOp),
    .e_md_op      (eOp),
    .e_valid      (eValid),
    .exc_flush    (excFlush),
    .md_busy      (mdBusy),
    .md_start     (mdStart),
    .stall_d      (stallD),
    .md_pending   (mdPending),
    .md_done      (mdDone),
    .md_proto_err (mdProtoErr),
    .md_timeout   (mdTimeout)
  );

  // Row: inputs {rst, d, e, ev, fl, busy} then expected {start, stall, pending, done, err}.
  typedef struct packed {
    logic       rst;
    logic [2:0] d;
    logic [2:0] e;
    logic       ev, fl, busy;
    logic       start, stall, pend, done, err;
  } vec_t;

  vec_t vecs [21] = '{
    15'b0_000_000_000_00000, 15'b0_101_001_110_00000, 15'b0_101_001_000_00000,
    15'b0_101_001_100_11000, 15'b0_101_000_001_01100, 15'b0_101_000_001_01100,
    15'b0_101_000_000_00110, 15'b0_000_000_000_00000, 15'b0_110_011_100_11000,
    15'b0_110_000_000_01100, 15'b0_110_000_000_00111, 15'b0_000_000_000_00001,
    15'b1_000_000_000_00001, 15'b0_000_000_000_00000, 15'b0_000_010_100_10000,
    15'b0_000_100_101_00100, 15'b0_001_000_001_01101, 15'b0_001_000_000_00111,
    15'b0_000_001_100_10001, 15'b1_000_000_001_00101, 15'b0_000_000_000_00000
  };

  // Reference model: an operation is tracked by its age in cycles since the start cycle.
  bit mPending, mErr, mTo, mKindDiv;
  int mAge, uLeft, latOverride;
  bit xStart, xStall, xDone, errNext;
  logic seenStart, seenStall, seenPending, seenDone, seenErr, seenTo, seenBusy;

  function automatic bit isMul(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input logic s, input logic st, input logic p,
                             input logic d, input logic e, input logic t);
    checkVal("md_start",     32'(mdStart),    32'(s));
    checkVal("stall_d",      32'(stallD),     32'(st));
    checkVal("md_pending",   32'(mdPending),  32'(p));
    checkVal("md_done",      32'(mdDone),     32'(d));
    checkVal("md_proto_err", 32'(mdProtoErr), 32'(e));
    checkVal("md_timeout",   32'(mdTimeout),  32'(t));
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    dOp      = v.d;
    eOp      = v.e;
    eValid   = v.ev;
    excFlush = v.fl;
    mdBusy   = v.busy;
  endtask

  task automatic modelEval();
    bit eMul, launching, waiting;
    eMul      = isMul(eOp);
    launching = mPending && (mAge == 1);
    waiting   = mPending && (mAge >= 2);
    xStart    = eValid && eMul && !excFlush && !mPending;
    xDone     = waiting && !mdBusy;
    xStall    = (dOp != NONE) && (xStart || launching || (waiting && mdBusy));
    errNext   = mErr || (launching && !mdBusy) || (eValid && eMul && mPending);
  endtask

  task automatic modelAdvance();
    if (reset) begin
      mPending = 0; mAge = 0; mErr = 0; mTo = 0; mKindDiv = 0; uLeft = 0;
    end else begin
`ifdef MD_WATCHDOG_EN
      if (mPending && (mAge - 1) > (mKindDiv ? 14 : 9)) mTo = 1;
`endif
      mErr = errNext;
      if (xStart) begin
        mPending = 1;
        mAge     = 1;
        mKindDiv = (eOp == DIV) || (eOp == DIVU);
        uLeft    = (latOverride >= 0) ? latOverride : (mKindDiv ? 10 : 5);
      end else begin
        if (xDone) mPending = 0;
        else if (mPending) mAge++;
        if (uLeft > 0) uLeft--;
      end
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    modelEval();
    seenStart = mdStart; seenStall = stallD; seenPending = mdPending;
    seenDone = mdDone; seenErr = mdProtoErr; seenTo = mdTimeout; seenBusy = mdBusy;
    checkOutput(xStart, xStall, mPending, xDone, mErr, mTo);
    @(posedge clk);
    modelAdvance();
    #1;
    mdBusy = (uLeft > 0);
  endtask

  task automatic doReset();
    reset = 1; dOp = NONE; eOp = NONE; eValid = 0; excFlush = 0;
    runCycle();
    reset = 0;
  endtask

  task automatic stallRun(input string name, input logic [2:0] op, input logic [2:0] dop,
                          input int expStalls);
    int stalls;
    bit released;
    stalls = 0; released = 0;
    dOp = dop; eOp = op; eValid = 1; excFlush = 0;
    for (int i = 0; i < 40 && !released; i++) begin
      runCycle();
      eOp = NONE; eValid = 0;
      if (seenStall) stalls++;
      else begin
        released = 1;
        checkVal({name, " done at release"}, 32'(seenDone), 32'd1);
        checkVal({name, " busy at release"}, 32'(seenBusy), 32'd0);
      end
    end
    checkVal({name, " released"}, 32'(released), 32'd1);
    checkVal({name, " stall cycles"}, 32'(stalls), 32'(expStalls));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global time limit: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    reset = 1; dOp = NONE; eOp = NONE; eValid = 0; excFlush = 0; mdBusy = 0;
    latOverride = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i].start, vecs[i].stall, vecs[i].pend, vecs[i].done, vecs[i].err, 1'b0);
      @(posedge clk);
      #1;
    end

    mPending = 0; mAge = 0; mErr = 0; mTo = 0; mKindDiv = 0; uLeft = 0;
    mdBusy = 0;
    doReset();

    stallRun("mult+mfhi", MULT, MFHL, 6);
    doReset();
    stallRun("div+mthi", DIV, MTHL, 11);
    doReset();

    dOp = MFHL; eOp = MULT; eValid = 1; excFlush = 1;
    runCycle();
    checkVal("flush start", 32'(seenStart), 32'd0);
    checkVal("flush stall", 32'(seenStall), 32'd0);
    excFlush = 0; eValid = 0; eOp = NONE;
    runCycle();
    checkVal("flush stays idle", 32'(seenPending), 32'd0);

    dOp = MTHL; eOp = DIV; eValid = 1;
    runCycle();
    eOp = NONE; eValid = 0;
    repeat (2) runCycle();
    reset = 1;
    runCycle();
    reset = 0;
    runCycle();
    checkVal("reset mid div pending", 32'(seenPending), 32'd0);
    checkVal("reset mid div stall",   32'(seenStall),   32'd0);
    checkVal("reset mid div err",     32'(seenErr),     32'd0);
    checkVal("reset mid div done",    32'(seenDone),    32'd0);

    latOverride = 0;
    dOp = NONE; eOp = MULT; eValid = 1;
    runCycle();
    eOp = NONE; eValid = 0;
    runCycle();
    runCycle();
    checkVal("no busy proto_err", 32'(seenErr), 32'd1);
    latOverride = -1;
    doReset();

`ifdef MD_WATCHDOG_EN
    begin
      bit gotDone;
      gotDone = 0;
      latOverride = 20;
      eOp = DIV; eValid = 1;
      runCycle();
      eOp = NONE; eValid = 0;
      for (int i = 0; i < 40 && !gotDone; i++) begin
        runCycle();
        if (seenDone) gotDone = 1;
      end
      checkVal("long div done", 32'(gotDone), 32'd1);
      checkVal("long div timeout", 32'(seenTo), 32'd1);
      latOverride = -1;
      doReset();
    end
`endif

    for (int c = 0; c < 1500; c++) begin
      int r;
      reset    = ($urandom_range(99) == 0);
      dOp      = 3'($urandom_range(6));
      eOp      = 3'($urandom_range(6));
      eValid   = ($urandom_range(3) != 0);
      excFlush = ($urandom_range(9) == 0);
      if (mPending && isMul(eOp) && ($urandom_range(49) != 0)) eValid = 0;
      r = int'($urandom_range(19));
      latOverride = (r == 0) ? 0 : (r == 1) ? 20 : -1;
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
